// File: rtl/minterm_sweep_checker_if.sv
// rtl/minterm_sweep_checker_if.sv - handshake/result bundle between sweep checker, FUT and controller
//
// Purpose: groups the sweep checker's non-clock signals.
// Ports (signals):
//   start          - begin a sweep
//   abcd_out[3:0]  - minterm driven to the FUT ([3]=a .. [0]=d)
//   f_in           - FUT output
//   busy, done     - sweep in progress / one-cycle completion pulse
//   pass           - observed table matched the expected table
//   truth_table    - observed table, bit m = f for minterm m
//   fail_count     - number of mismatching minterms (0..16)
//   first_fail_idx - lowest mismatching minterm
// Modports: master = checker side, slave = controller/FUT side.
interface minterm_sweep_checker_if;
  logic        start;
  logic [3:0]  abcd_out;
  logic        f_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] truth_table;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail_idx;

  modport master (
    input  start, f_in,
    output abcd_out, busy, done, pass, truth_table, fail_count, first_fail_idx
  );

  modport slave (
    output start, f_in,
    input  abcd_out, busy, done, pass, truth_table, fail_count, first_fail_idx
  );
endinterface

// File: rtl/minterm_sweep_checker.sv
// rtl/minterm_sweep_checker.sv - walks all 16 minterms through a 4-input FUT and checks its truth table
//
// Purpose: drives each minterm for SETTLE_CYCLES cycles, samples f_in for one
// cycle, accumulates the observed table and compares it with EXPECTED_TT.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - minterm_sweep_checker_if.master (start, abcd_out, f_in, busy, done,
//          pass, truth_table, fail_count, first_fail_idx)
// Parameters:
//   SETTLE_CYCLES - cycles abcd_out is held before f_in is sampled (1..15)
//   EXPECTED_TT   - expected truth table, bit m = f for minterm {a,b,c,d}=m
// Optional macro STICKY_HALT_EN: stop the sweep at the first mismatch.
module minterm_sweep_checker #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED_TT   = 16'h73F0
) (
  input logic                     clk,
  input logic                     rst,
  minterm_sweep_checker_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  m_q, m_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tt_q, tt_d;
  logic [4:0]  fc_q, fc_d;
  logic [3:0]  ffi_q, ffi_d;
  logic        pass_q, pass_d;
  logic        done_q, done_d;
  logic        mismatch;
  logic        finish;

  assign mismatch = (bus.f_in != EXPECTED_TT[m_q]);

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    fc_d    = fc_q;
    ffi_d   = ffi_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    finish  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = DRIVE;
          m_d     = 4'd0;
          cnt_d   = 4'd0;
          tt_d    = 16'd0;
          fc_d    = 5'd0;
          ffi_d   = 4'd0;
          pass_d  = 1'b0;
        end
      end

      DRIVE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(SETTLE_CYCLES - 1)) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        tt_d[m_q] = bus.f_in;
        if (mismatch) begin
          fc_d = fc_q + 5'd1;
          if (fc_q == 5'd0) begin
            ffi_d = m_q;
          end
        end
`ifdef STICKY_HALT_EN
        finish = mismatch || (m_q == 4'd15);
`else
        finish = (m_q == 4'd15);
`endif
        if (finish) begin
          // m stays put so abcd_out keeps showing the last minterm tested
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (fc_d == 5'd0);
        end else begin
          state_d = DRIVE;
          m_d     = m_q + 4'd1;
          cnt_d   = 4'd0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= 4'd0;
      cnt_q   <= 4'd0;
      tt_q    <= 16'd0;
      fc_q    <= 5'd0;
      ffi_q   <= 4'd0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      fc_q    <= fc_d;
      ffi_q   <= ffi_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  assign bus.abcd_out       = m_q;
  assign bus.busy           = (state_q == DRIVE) || (state_q == SAMPLE);
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.truth_table    = tt_q;
  assign bus.fail_count     = fc_q;
  assign bus.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// tb/tb_minterm_sweep_checker.sv - directed self-checking bench for minterm_sweep_checker
module tb_minterm_sweep_checker;

  logic        clk;
  logic        rst;
  logic [15:0] fut_tt;
  int          errors;
  int          checks;
  int          lat;
  int          dcount;

  minterm_sweep_checker_if ifc ();

  // Combinational FUT model: f is looked up from the table under test
  assign ifc.f_in = fut_tt[ifc.abcd_out];

  minterm_sweep_checker #(
    .SETTLE_CYCLES(2),
    .EXPECTED_TT  (16'h73F0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start so it is accepted on the next rising edge; returns at the
  // falling edge just after the accept edge.
  task automatic kick();
    @(negedge clk);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  // Counts cycles from the accept edge until done; optionally re-pulses start
  // at cycle offsets pa/pb. Bounded at 200 cycles.
  task automatic wait_done(input int pa, input int pb, output int n);
    n = 0;
    while (ifc.done !== 1'b1 && n < 200) begin
      ifc.start = (n == pa || n == pb) ? 1'b1 : 1'b0;
      @(negedge clk);
      n++;
    end
    ifc.start = 1'b0;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    ifc.start = 1'b0;
    fut_tt    = 16'h73F0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_abcd", 32'(ifc.abcd_out), 32'h0);
    chk("rst_busy", 32'(ifc.busy), 32'h0);
    chk("rst_done", 32'(ifc.done), 32'h0);
    chk("rst_pass", 32'(ifc.pass), 32'h0);
    chk("rst_tt", 32'(ifc.truth_table), 32'h0);
    chk("rst_fc", 32'(ifc.fail_count), 32'h0);
    chk("rst_ffi", 32'(ifc.first_fail_idx), 32'h0);
    rst = 1'b0;

    // Correct FUT
    kick();
    chk("good_busy0", 32'(ifc.busy), 32'h1);
    chk("good_abcd0", 32'(ifc.abcd_out), 32'h0);
    wait_done(-1, -1, lat);
    chk("good_lat", 32'(lat), 32'd48);
    chk("good_tt", 32'(ifc.truth_table), 32'h73F0);
    chk("good_pass", 32'(ifc.pass), 32'h1);
    chk("good_fc", 32'(ifc.fail_count), 32'h0);
    chk("good_ffi", 32'(ifc.first_fail_idx), 32'h0);
    chk("good_busy", 32'(ifc.busy), 32'h0);
    chk("good_abcd15", 32'(ifc.abcd_out), 32'hF);
    @(negedge clk);
    chk("good_done_1cyc", 32'(ifc.done), 32'h0);
    chk("good_hold_pass", 32'(ifc.pass), 32'h1);

    // Restart from DONE with bits 5 and 11 flipped
    fut_tt = 16'h7BD0;
    kick();
    chk("restart_tt_clr", 32'(ifc.truth_table), 32'h0);
    chk("restart_pass_clr", 32'(ifc.pass), 32'h0);
    chk("restart_busy", 32'(ifc.busy), 32'h1);
    wait_done(-1, -1, lat);
    chk("flip_lat", 32'(lat), 32'd48);
    chk("flip_tt", 32'(ifc.truth_table), 32'h7BD0);
    chk("flip_fc", 32'(ifc.fail_count), 32'd2);
    chk("flip_ffi", 32'(ifc.first_fail_idx), 32'd5);
    chk("flip_pass", 32'(ifc.pass), 32'h0);

    // FUT stuck at 1
    fut_tt = 16'hFFFF;
    kick();
    wait_done(-1, -1, lat);
    chk("stuck_tt", 32'(ifc.truth_table), 32'hFFFF);
    chk("stuck_fc", 32'(ifc.fail_count), 32'd7);
    chk("stuck_ffi", 32'(ifc.first_fail_idx), 32'd0);
    chk("stuck_pass", 32'(ifc.pass), 32'h0);

    // Reset 20 cycles into a sweep
    fut_tt = 16'h73F0;
    kick();
    repeat (20) @(negedge clk);
    chk("mid_abcd", 32'(ifc.abcd_out), 32'd6);
    chk("mid_busy", 32'(ifc.busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(ifc.busy), 32'h0);
    chk("midrst_abcd", 32'(ifc.abcd_out), 32'h0);
    chk("midrst_tt", 32'(ifc.truth_table), 32'h0);
    chk("midrst_fc", 32'(ifc.fail_count), 32'h0);
    kick();
    wait_done(-1, -1, lat);
    chk("after_rst_lat", 32'(lat), 32'd48);
    chk("after_rst_tt", 32'(ifc.truth_table), 32'h73F0);
    chk("after_rst_pass", 32'(ifc.pass), 32'h1);

    // start re-pulsed mid-sweep is ignored
    kick();
    wait_done(10, 30, lat);
    chk("repulse_lat", 32'(lat), 32'd48);
    dcount = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ifc.done === 1'b1) dcount++;
    end
    chk("repulse_extra_done", 32'(dcount), 32'd0);
    chk("repulse_idle_busy", 32'(ifc.busy), 32'h0);

    // Simultaneous rst and start: rst wins
    @(negedge clk);
    rst       = 1'b1;
    ifc.start = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    ifc.start = 1'b0;
    chk("rst_start_busy", 32'(ifc.busy), 32'h0);
    chk("rst_start_pass", 32'(ifc.pass), 32'h0);
    @(negedge clk);
    chk("rst_start_stay", 32'(ifc.busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
